// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package rv_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    STOP  = 2'd3
  } fetch_state_e;

  localparam logic [PCSRC_W-1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_BR   = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JALR = 2'b10;

  localparam logic [OPC_W-1:0] OPC_EBREAK = 7'b1110011;
  localparam logic [XLEN-1:0]  INSTR_NOP  = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between fetch stage and memory.
interface instr_fetch_unit_if;
  import rv_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC selection (sequential, branch/JAL, JALR) with alignment check.
module pc_next_calc
  import rv_fetch_pkg::*;
(
  input  logic [XLEN-1:0]    pc,
  input  logic [PCSRC_W-1:0] pc_src,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    alu_result,
  output logic [XLEN-1:0]    next_pc,
  output logic               misaligned
);

  // pc_src of 2'b11 falls through to the sequential default
  always_comb begin
    next_pc = pc + XLEN'(4);
    case (pc_src)
      PCSRC_BR:   next_pc = pc + imm;
      PCSRC_JALR: next_pc = {alu_result[XLEN-1:1], 1'b0};
      default:    next_pc = pc + XLEN'(4);
    endcase
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, IDLE/FETCH/EXEC/STOP sequencing, instruction latch, retire counter.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic [PCSRC_W-1:0]  pc_src,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     alu_result,
  output logic [XLEN-1:0]     im_data,
  output logic                instr_valid,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                halted,
  output logic                fault,
  output logic [XLEN-1:0]     instret
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc_n, im_data_n, instret_n;
  logic            halted_n, fault_n;
  logic            imem_req_q;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  pc_next_calc u_pc_next_calc (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm        (imm),
    .alu_result (alu_result),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      im_data     <= INSTR_NOP;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instret     <= '0;
      imem_req_q  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      im_data     <= im_data_n;
      instr_valid <= (state_n == EXEC);
      halted      <= halted_n;
      fault       <= fault_n;
      instret     <= instret_n;
      imem_req_q  <= (state_n == FETCH);
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    im_data_n = im_data;
    instret_n = instret;
    halted_n  = halted;
    fault_n   = fault;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          im_data_n = imem.imem_rdata;
          state_n   = EXEC;
        end
      end
      EXEC: begin
        // EBREAK and misaligned targets both freeze pc and are not retired
        if (im_data[OPC_W-1:0] == OPC_EBREAK) begin
          state_n  = STOP;
          halted_n = 1'b1;
        end else if (misaligned) begin
          state_n = STOP;
          fault_n = 1'b1;
        end else begin
          pc_n      = next_pc;
          instret_n = instret + XLEN'(1);
          state_n   = FETCH;
        end
      end
      default: state_n = STOP;
    endcase
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc;
  assign pc_plus4       = pc + XLEN'(4);

endmodule
